// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: round counts, sigma rotate/shift amounts,
// FSM state type and the per-width sigma functions.
package sha2_pkg;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  localparam int S0_ROT_A_256 = 7;
  localparam int S0_ROT_B_256 = 18;
  localparam int S0_SHR_256   = 3;
  localparam int S1_ROT_A_256 = 17;
  localparam int S1_ROT_B_256 = 19;
  localparam int S1_SHR_256   = 10;

  localparam int S0_ROT_A_512 = 1;
  localparam int S0_ROT_B_512 = 8;
  localparam int S0_SHR_512   = 7;
  localparam int S1_ROT_A_512 = 19;
  localparam int S1_ROT_B_512 = 61;
  localparam int S1_SHR_512   = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] sigma0_256(input logic [31:0] x);
    return rotr32(x, S0_ROT_A_256) ^ rotr32(x, S0_ROT_B_256) ^ (x >> S0_SHR_256);
  endfunction

  function automatic logic [31:0] sigma1_256(input logic [31:0] x);
    return rotr32(x, S1_ROT_A_256) ^ rotr32(x, S1_ROT_B_256) ^ (x >> S1_SHR_256);
  endfunction

  function automatic logic [63:0] sigma0_512(input logic [63:0] x);
    return rotr64(x, S0_ROT_A_512) ^ rotr64(x, S0_ROT_B_512) ^ (x >> S0_SHR_512);
  endfunction

  function automatic logic [63:0] sigma1_512(input logic [63:0] x);
    return rotr64(x, S1_ROT_A_512) ^ rotr64(x, S1_ROT_B_512) ^ (x >> S1_SHR_512);
  endfunction

endpackage

// File: rtl/sha2_sched_word.sv
// Combinational next-word adder tree: W[t+16] from W[t+14], W[t+9], W[t+1], W[t].
// Zero latency, no flow control; the caller decides when to consume the result.
module sha2_sched_word
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] w14,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w0,
  output logic [WORD_W-1:0] w_new
);

  // Only the branch matching WORD_W is elaborated, so all widths line up exactly.
  if (WORD_W == 32) begin : g_w32
    assign w_new = sigma1_256(w14) + w9 + sigma0_256(w1) + w0;
  end else begin : g_w64
    assign w_new = sigma1_512(w14) + w9 + sigma0_512(w1) + w0;
  end

endmodule

// File: rtl/sha2_msg_sched_gen.sv
// SHA-2 message-schedule engine: takes a 16-word (or 8-word, self-padded) block and streams W[0..ROUNDS-1].
// First word one cycle after accept; w_ready low freezes the output word and the window.
module sha2_msg_sched_gen
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  input  logic [16*WORD_W-1:0]   blk_data,
  input  logic                   pad_mode,
  input  logic                   abort,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [WORD_W-1:0]      w_data,
  output logic [IDX_W-1:0]       w_idx,
  output logic                   w_last
);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("sha2_msg_sched_gen: WORD_W must be 32 or 64");
  end

  localparam int               ROUNDS   = (WORD_W == 32) ? ROUNDS_256 : ROUNDS_512;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  window [16];
  logic [WORD_W-1:0]  load   [16];
  logic [WORD_W-1:0]  w_new;

  sha2_sched_word #(.WORD_W(WORD_W)) u_word (
    .w14   (window[14]),
    .w9    (window[9]),
    .w1    (window[1]),
    .w0    (window[0]),
    .w_new (w_new)
  );

  // Padded load: 8-word message, a single 1 bit, zeros, then the 8*WORD_W bit length.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      load[i] = blk_data[(15-i)*WORD_W +: WORD_W];
    end
    if (pad_mode) begin
      for (int i = 8; i < 16; i++) begin
        load[i] = '0;
      end
      load[8]  = {1'b1, {(WORD_W-1){1'b0}}};
      load[15] = WORD_W'(8 * WORD_W);
    end
  end

  assign blk_ready = (state == IDLE) && !abort;
  assign w_valid   = (state == RUN);
  assign w_data    = window[0];
  assign w_idx     = idx;
  assign w_last    = (state == RUN) && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      for (int i = 0; i < 16; i++) begin
        window[i] <= '0;
      end
    end else if (abort) begin
      // Flush keeps the window contents; only control state is reset.
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            window <= load;
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (w_ready) begin
            if (w_last) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              for (int i = 0; i < 15; i++) begin
                window[i] <= window[i+1];
              end
              window[15] <= w_new;
              idx        <= idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_msg_sched_gen.sv
// Scoreboard bench for sha2_msg_sched_gen: one 32-bit and one 64-bit instance, expected words queued at issue.
module tb_sha2_msg_sched_gen;

  typedef struct {
    logic [63:0] d;
    logic [6:0]  i;
    logic        l;
  } exp_t;

  logic clk;
  logic rst;

  logic          b32_valid, b32_ready, p32, a32, wv32, wr32, wl32;
  logic [511:0]  b32_data;
  logic [31:0]   wd32;
  logic [6:0]    wi32;

  logic          b64_valid, b64_ready, p64, a64, wv64, wr64, wl64;
  logic [1023:0] b64_data;
  logic [63:0]   wd64;
  logic [6:0]    wi64;

  int vectors;
  int miscompares;

  exp_t        q32[$];
  exp_t        q64[$];
  logic [63:0] mw    [80];
  logic [31:0] cap32 [128];
  logic [63:0] cap64 [128];

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

  sha2_msg_sched_gen #(.WORD_W(32)) dut32 (
    .clk(clk), .rst(rst), .blk_valid(b32_valid), .blk_ready(b32_ready), .blk_data(b32_data),
    .pad_mode(p32), .abort(a32), .w_valid(wv32), .w_ready(wr32), .w_data(wd32),
    .w_idx(wi32), .w_last(wl32)
  );

  sha2_msg_sched_gen #(.WORD_W(64)) dut64 (
    .clk(clk), .rst(rst), .blk_valid(b64_valid), .blk_ready(b64_ready), .blk_data(b64_data),
    .pad_mode(p64), .abort(a64), .w_valid(wv64), .w_ready(wr64), .w_data(wd64),
    .w_idx(wi64), .w_last(wl64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'b0, x[63:7]};
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'b0, x[63:6]};
  endfunction

  // Reference schedule in the classic t-indexed form.
  task automatic build_model(input logic [1023:0] d, input bit pad, input bit is64);
    logic [31:0] t32;
    for (int i = 0; i < 16; i++) begin
      if (pad && i >= 8) mw[i] = 64'h0;
      else if (is64)     mw[i] = d[(15-i)*64 +: 64];
      else               mw[i] = {32'h0, d[(15-i)*32 +: 32]};
    end
    if (pad) begin
      mw[8]  = is64 ? 64'h8000000000000000 : 64'h0000000080000000;
      mw[15] = is64 ? 64'h200 : 64'h100;
    end
    for (int t = 16; t < 80; t++) begin
      if (is64) begin
        mw[t] = s1_64(mw[t-2]) + mw[t-7] + s0_64(mw[t-15]) + mw[t-16];
      end else begin
        t32   = s1_32(mw[t-2][31:0]) + mw[t-7][31:0] + s0_32(mw[t-15][31:0]) + mw[t-16][31:0];
        mw[t] = {32'h0, t32};
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && wv32 && wr32) begin
      if (q32.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL w32_unexpected: got word idx %0d, expected none", wi32);
      end else begin
        e = q32.pop_front();
        check("w32_data", 64'(wd32), e.d);
        check("w32_idx",  64'(wi32), 64'(e.i));
        check("w32_last", 64'(wl32), 64'(e.l));
      end
      cap32[wi32] = wd32;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && wv64 && wr64) begin
      if (q64.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL w64_unexpected: got word idx %0d, expected none", wi64);
      end else begin
        e = q64.pop_front();
        check("w64_data", wd64, e.d);
        check("w64_idx",  64'(wi64), 64'(e.i));
        check("w64_last", 64'(wl64), 64'(e.l));
      end
      cap64[wi64] = wd64;
    end
  end

  task automatic wait_for(input bit is64, input int target, input bit want_last, input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (is64) found = wv64 && (want_last ? wl64 : (wi64 == 7'(target)));
      else      found = wv32 && (want_last ? wl32 : (wi32 == 7'(target)));
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout, expected condition not reached", name);
    end
  endtask

  // Queue the expected stream, present the block, and check first-word latency.
  task automatic offer(input bit is64, input logic [1023:0] d, input bit pad);
    bit found;
    int rounds;
    rounds = is64 ? 80 : 64;
    build_model(d, pad, is64);
    for (int t = 0; t < rounds; t++) begin
      if (is64) q64.push_back('{d: mw[t], i: 7'(t), l: (t == rounds - 1)});
      else      q32.push_back('{d: mw[t], i: 7'(t), l: (t == rounds - 1)});
    end
    @(posedge clk); #1;
    if (is64) begin b64_data = d; p64 = pad; b64_valid = 1'b1; end
    else      begin b32_data = d[511:0]; p32 = pad; b32_valid = 1'b1; end
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      found = is64 ? b64_ready : b32_ready;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL blk_accept: timeout, blk_ready never 1");
    end
    @(posedge clk); #1;
    b32_valid = 1'b0;
    b64_valid = 1'b0;
    @(negedge clk);
    check("lat_valid", 64'(is64 ? wv64 : wv32), 64'h1);
    check("lat_idx",   64'(is64 ? wi64 : wi32), 64'h0);
    check("lat_data",  is64 ? wd64 : 64'(wd32), mw[0]);
  endtask

  task automatic finish_block(input bit is64, input string name);
    wait_for(is64, 0, 1'b1, name);
    @(negedge clk);
    check("idle_w_valid",   64'(is64 ? wv64 : wv32), 64'h0);
    check("idle_blk_ready", 64'(is64 ? b64_ready : b32_ready), 64'h1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    b32_valid = 1'b0; b32_data = '0; p32 = 1'b0; a32 = 1'b0; wr32 = 1'b1;
    b64_valid = 1'b0; b64_data = '0; p64 = 1'b0; a64 = 1'b0; wr64 = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_w_valid",   64'(wv32), 64'h0);
    check("rst_w_last",    64'(wl32), 64'h0);
    check("rst_w_idx",     64'(wi32), 64'h0);
    check("rst_w_data",    64'(wd32), 64'h0);
    check("rst_blk_ready", 64'(b32_ready), 64'h1);
    check("rst64_w_data",  wd64, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_blk_ready", 64'(b32_ready), 64'h1);

    // "abc" block, no padding by the engine
    offer(1'b0, {512'h0, ABC}, 1'b0);
    finish_block(1'b0, "abc_last");
    check("abc_w16", 64'(cap32[16]), 64'h61626380);
    check("abc_w17", 64'(cap32[17]), 64'h000F0000);
    check("abc_w18", 64'(cap32[18]), 64'h7DA86405);
    check("abc_w19", 64'(cap32[19]), 64'h600003C6);

    // Internal padding; lower half of blk_data is junk and must be ignored
    offer(1'b0, {512'h0, 256'h0, {256{1'b1}}}, 1'b1);
    finish_block(1'b0, "pad32_last");
    check("pad32_w8",  64'(cap32[8]),  64'h80000000);
    check("pad32_w15", 64'(cap32[15]), 64'h00000100);
    check("pad32_w16", 64'(cap32[16]), 64'h00000000);
    check("pad32_w17", 64'(cap32[17]), 64'h00A00000);

    // Backpressure: hold at idx 20 for 5 cycles
    offer(1'b0, {512'h0, ABC}, 1'b0);
    wait_for(1'b0, 19, 1'b0, "bp_reach19");
    @(posedge clk); #1;
    wr32 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 64'(wv32), 64'h1);
      check("bp_idx",   64'(wi32), 64'd20);
      check("bp_data",  64'(wd32), mw[20]);
    end
    @(posedge clk); #1;
    wr32 = 1'b1;
    finish_block(1'b0, "bp_last");

    // Reset mid-stream
    offer(1'b0, {512'h0, 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0, 256'h0}, 1'b1);
    wait_for(1'b0, 30, 1'b0, "rst_reach30");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_w_valid",   64'(wv32), 64'h0);
    check("midrst_blk_ready", 64'(b32_ready), 64'h1);
    check("midrst_w_idx",     64'(wi32), 64'h0);
    q32.delete();
    offer(1'b0, {512'h0, ABC}, 1'b0);
    check("restart_w0", 64'(wd32), 64'h61626380);
    finish_block(1'b0, "restart_last");

    // Abort at idx 10 together with a competing block offer
    offer(1'b0, {512'h0, ABC}, 1'b0);
    wait_for(1'b0, 9, 1'b0, "abort_reach9");
    @(posedge clk); #1;
    a32 = 1'b1;
    wr32 = 1'b0;
    b32_valid = 1'b1;
    b32_data = {16{32'hDEADBEEF}};
    @(negedge clk);
    check("abort_blk_ready", 64'(b32_ready), 64'h0);
    check("abort_idx",       64'(wi32), 64'd10);
    @(posedge clk); #1;
    a32 = 1'b0;
    b32_valid = 1'b0;
    wr32 = 1'b1;
    @(negedge clk);
    check("abort_w_valid",   64'(wv32), 64'h0);
    check("abort_idle_rdy",  64'(b32_ready), 64'h1);
    check("abort_idx_clr",   64'(wi32), 64'h0);
    q32.delete();
    offer(1'b0, {512'h0, 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888, 256'h0}, 1'b1);
    finish_block(1'b0, "post_abort_last");

    // SHA-512 width, zero message with internal padding
    offer(1'b1, 1024'h0, 1'b1);
    finish_block(1'b1, "pad64_last");
    check("pad64_w8",  cap64[8],  64'h8000000000000000);
    check("pad64_w15", cap64[15], 64'h0000000000000200);

    check("q32_drained", 64'(q32.size()), 64'h0);
    check("q64_drained", 64'(q64.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha2_msg_sched_gen.md
Name: sha2_msg_sched_gen

Overview:
Parametrised SHA-2 message-schedule engine serving both SHA-256 (WORD_W=32, 64 rounds) and SHA-512 (WORD_W=64, 80 rounds).
- Accepts one 16-word block over a valid/ready handshake, or an 8-word message that it pads internally.
- Streams W[0..ROUNDS-1] to the compression core over a valid/ready handshake with backpressure.
- Replaces the fixed 32-bit, t-indexed schedule. Uses a uniform 16-word sliding window: the output is always window[0].

Parameters:
WORD_W, 32, word width; only 32 or 64 are legal (elaboration error otherwise).
ROUNDS, (WORD_W==32 ? 64 : 80), schedule length. Derived; not overridable.
IDX_W, 7, width of the w_idx output.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
blk_valid  in  1  block offered
blk_ready  out  1  block accepted when blk_valid && blk_ready
blk_data  in  16*WORD_W  block; word 0 is in the MSBs (big-endian)
pad_mode  in  1  sampled with the block; 1 = use only the upper 8 words and synthesise the padding
abort  in  1  synchronous flush to IDLE
w_valid  out  1  w_data is W[w_idx]
w_ready  in  1  consumer accepts the word
w_data  out  WORD_W  schedule word
w_idx  out  IDX_W  round index of w_data
w_last  out  1  high with w_valid when w_idx == ROUNDS-1

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, window cleared to 0, idx=0.
  - Outputs: w_valid=0, w_last=0, w_idx=0, w_data=0, blk_ready=1 (combinational from IDLE, so it reads 1 in the first cycle after reset).
  - Reset mid-stream discards the block; no further words are emitted.
- FSM: two states, IDLE and RUN.
  - blk_ready = (state==IDLE) && !abort.
  - IDLE: on block accept, load the window and set idx=0, then go to RUN. W[0] appears on w_valid the next cycle (1-cycle latency).
  - RUN: w_valid=1, w_data=window[0], w_idx=idx, w_last=(idx==ROUNDS-1).
  - On w_valid && w_ready, if !w_last:
    - shift window left by one: window[i] <= window[i+1];
    - window[15] <= W_new; idx <= idx+1.
  - On w_valid && w_ready && w_last: go to IDLE, clear idx, w_valid=0 next cycle. A new block can be accepted from the following cycle, giving one bubble between blocks.
  - w_valid=1 && w_ready=0: w_data, w_idx and w_last hold stable. No shift occurs.
- Next-word recurrence: W_new = σ1(window[14]) + window[9] + σ0(window[1]) + window[0], computed mod 2^WORD_W. This is W[t+16] when window[0]=W[t]. Words appended beyond ROUNDS-1 are computed but never emitted.
- Sigma functions:
  - WORD_W=32: σ0 = ROTR7 ^ ROTR18 ^ SHR3; σ1 = ROTR17 ^ ROTR19 ^ SHR10.
  - WORD_W=64: σ0 = ROTR1 ^ ROTR8 ^ SHR7; σ1 = ROTR19 ^ ROTR61 ^ SHR6.
- Window load, pad_mode=0: window[i] = blk_data word i.
- Window load, pad_mode=1:
  - words 0..7 come from blk_data words 0..7; the lower half of blk_data is ignored;
  - word 8 = 1 in the MSB only (top bit set);
  - words 9..14 = 0;
  - word 15 = 8*WORD_W (message bit length: 0x100 for 32, 0x200 for 64).
- abort:
  - in any state, go to IDLE next cycle with w_valid=0 and idx=0;
  - the window is not cleared;
  - abort with blk_valid in the same cycle: the block is not accepted (blk_ready=0).
- w_ready is ignored when w_valid=0. blk_valid is ignored in RUN.

Decomposition:
- Package sha2_pkg holds:
  - constants: ROUNDS_256=64, ROUNDS_512=80, ROTR/SHR amounts per width;
  - typedef state_t {IDLE, RUN};
  - functions rotr and sigma0/sigma1, selected by width.
- One sub-module: sha2_sched_word, the combinational W_new adder tree parametrised by WORD_W. It is reused by future unrolled variants.

Test Plan:
- WORD_W=32, pad_mode=0, block = SHA-256 "abc" padded (W0=0x61626380, W15=0x00000018, other words 0), w_ready=1 -> W0 one cycle after accept; W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6; 64 words; w_last on idx 63; blk_ready=1 the cycle after.
- WORD_W=32, pad_mode=1, 8 zero words -> W8=0x80000000, W15=0x00000100, W16=0x00000000, W17=0x00A00000.
- Backpressure: w_ready low for 5 cycles at idx 20 -> w_data and w_idx=20 held stable; W21 follows once w_ready is high; sequence identical to the stall-free run.
- WORD_W=64, pad_mode=1, zero message -> 80 words; W8=0x8000000000000000, W15=0x200; w_last at idx 79.
- rst asserted at idx 30 -> next cycle w_valid=0, blk_ready=1; a fresh block restarts at idx 0 with correct W0.
- abort at idx 10 with blk_valid=1 in the same cycle -> block not accepted; next cycle IDLE; a subsequent block is accepted and emits from idx 0.
